// File: rtl/ece385_pio_in_irq.sv
// Avalon-MM parallel input port with per-bit synchronizer, optional debounce,
// edge capture register and maskable level interrupt.
module ece385_pio_in_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE =
        (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_cap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    filt <= IDLE;
                end else begin
                    filt <= synced;
                end
            end
        end else begin : g_debounce
            localparam int CW =
                (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0][CW-1:0] cnt;

            // A bit flips only after N consecutive disagreeing samples.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt  <= '0;
                    filt <= IDLE;
                end else begin
                    for (int b = 0; b < WIDTH; b++) begin
                        if (synced[b] == filt[b]) begin
                            cnt[b] <= '0;
                        end else if (cnt[b] == LAST) begin
                            cnt[b]  <= '0;
                            filt[b] <= ~filt[b];
                        end else begin
                            cnt[b] <= cnt[b] + CW'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d <= IDLE;
        end else begin
            filt_d <= filt;
        end
    end

    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            0:       edge_hit = filt & ~filt_d;
            1:       edge_hit = ~filt & filt_d;
            default: edge_hit = filt ^ filt_d;
        endcase
    end

    assign wr_en   = chipselect & ~write_n;
    assign wr_mask = wr_en && (address == ADDR_IRQMASK);
    assign wr_cap  = wr_en && (address == ADDR_EDGECAP);
    assign cap_clr = wr_cap ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_mask) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    // A fresh edge outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = filt;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_cap;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |(edge_cap & irq_mask);

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wd;
            assign unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule
